// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RISC-V core constants and types, including the BTB geometry,
// branch predictor state/prediction types and the 2-bit saturating counter helper.
package riscv_pkg;

   localparam int XLEN               = 32;
   localparam int BTB_SIZE           = 64;
   localparam int BTB_INDEX_WIDTH    = $clog2(BTB_SIZE);
   localparam int BTB_TAG_WIDTH      = XLEN - BTB_INDEX_WIDTH - 2;
   localparam int PERF_COUNTER_WIDTH = 32;

   typedef enum logic [1:0] {
      PRED_STRONG_NOT_TAKEN = 2'b00,
      PRED_WEAK_NOT_TAKEN   = 2'b01,
      PRED_WEAK_TAKEN       = 2'b10,
      PRED_STRONG_TAKEN     = 2'b11
   } branch_pred_state_e;

   typedef struct packed {
      logic               valid;
      logic               taken;
      logic [XLEN-1:0]    target;
      branch_pred_state_e state;
   } branch_pred_t;

   function automatic branch_pred_state_e sat_cnt_update(input branch_pred_state_e state,
                                                         input logic taken);
      if (taken)
         return (state == PRED_STRONG_TAKEN) ? state : branch_pred_state_e'(state + 2'd1);
      return (state == PRED_STRONG_NOT_TAKEN) ? state : branch_pred_state_e'(state - 2'd1);
   endfunction

endpackage

// File: rtl/btb_array.sv
// btb_array: direct-mapped BTB storage (valid/tag/target/state) with a lookup read port,
// a write port with readback of the addressed entry, and a synchronous flush of all valid bits.
module btb_array
   import riscv_pkg::*;
#(
   parameter int ENTRIES = BTB_SIZE,
   parameter int IDX_W   = $clog2(ENTRIES),
   parameter int TAG_W   = XLEN - IDX_W - 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               flush_i,
   input  logic [IDX_W-1:0]   rd_idx_i,
   output logic               rd_valid_o,
   output logic [TAG_W-1:0]   rd_tag_o,
   output logic [XLEN-1:0]    rd_target_o,
   output branch_pred_state_e rd_state_o,
   input  logic               we_i,
   input  logic [IDX_W-1:0]   wr_idx_i,
   input  logic               wr_valid_i,
   input  logic [TAG_W-1:0]   wr_tag_i,
   input  logic [XLEN-1:0]    wr_target_i,
   input  branch_pred_state_e wr_state_i,
   output logic               rb_valid_o,
   output logic [TAG_W-1:0]   rb_tag_o,
   output logic [XLEN-1:0]    rb_target_o,
   output branch_pred_state_e rb_state_o
);

   logic [ENTRIES-1:0] r_valid;
   logic [TAG_W-1:0]   r_tag    [ENTRIES];
   logic [XLEN-1:0]    r_target [ENTRIES];
   branch_pred_state_e r_state  [ENTRIES];

   // Only valid bits are reset; stale payload is invisible behind a cleared valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_valid <= '0;
      else if (flush_i)
         r_valid <= '0;
      else if (we_i)
         r_valid[wr_idx_i] <= wr_valid_i;
   end

   always_ff @(posedge clk) begin
      if (we_i) begin
         r_tag[wr_idx_i]    <= wr_tag_i;
         r_target[wr_idx_i] <= wr_target_i;
         r_state[wr_idx_i]  <= wr_state_i;
      end
   end

   assign rd_valid_o  = r_valid[rd_idx_i];
   assign rd_tag_o    = r_tag[rd_idx_i];
   assign rd_target_o = r_target[rd_idx_i];
   assign rd_state_o  = r_state[rd_idx_i];

   assign rb_valid_o  = r_valid[wr_idx_i];
   assign rb_tag_o    = r_tag[wr_idx_i];
   assign rb_target_o = r_target[wr_idx_i];
   assign rb_state_o  = r_state[wr_idx_i];

endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: IF-stage BTB + 2-bit counter predictor with EX-stage training.
// Define BPU_PERF_EN to build the saturating lookup/hit/mispredict counters.
module branch_predictor
   import riscv_pkg::*;
#(
   parameter int ENTRIES = BTB_SIZE,
   parameter int IDX_W   = $clog2(ENTRIES),
   parameter int TAG_W   = XLEN - IDX_W - 2,
   parameter int CNT_W   = PERF_COUNTER_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush_i,
   input  logic [XLEN-1:0]  pc_i,
   output branch_pred_t     pred_o,
   input  logic             upd_valid_i,
   input  logic [XLEN-1:0]  upd_pc_i,
   input  logic             upd_is_branch_i,
   input  logic             upd_is_jump_i,
   input  logic             upd_is_jalr_i,
   input  logic             upd_taken_i,
   input  logic [XLEN-1:0]  upd_target_i,
   input  logic             upd_mispred_i,
   output logic [CNT_W-1:0] perf_lookups_o,
   output logic [CNT_W-1:0] perf_hits_o,
   output logic [CNT_W-1:0] perf_mispred_o
);

   logic               w_rd_valid, w_rb_valid, w_hit, w_upd_hit;
   logic [TAG_W-1:0]   w_rd_tag, w_rb_tag;
   logic [XLEN-1:0]    w_rd_target, w_rb_target;
   branch_pred_state_e w_rd_state, w_rb_state;
   logic               w_we, w_wr_valid;
   logic [XLEN-1:0]    w_wr_target;
   branch_pred_state_e w_wr_state;
   logic               w_unused;

   btb_array #(.ENTRIES(ENTRIES), .IDX_W(IDX_W), .TAG_W(TAG_W)) u_btb (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush_i     (flush_i),
      .rd_idx_i    (pc_i[IDX_W+1:2]),
      .rd_valid_o  (w_rd_valid),
      .rd_tag_o    (w_rd_tag),
      .rd_target_o (w_rd_target),
      .rd_state_o  (w_rd_state),
      .we_i        (w_we),
      .wr_idx_i    (upd_pc_i[IDX_W+1:2]),
      .wr_valid_i  (w_wr_valid),
      .wr_tag_i    (upd_pc_i[XLEN-1:IDX_W+2]),
      .wr_target_i (w_wr_target),
      .wr_state_i  (w_wr_state),
      .rb_valid_o  (w_rb_valid),
      .rb_tag_o    (w_rb_tag),
      .rb_target_o (w_rb_target),
      .rb_state_o  (w_rb_state)
   );

   assign w_hit     = w_rd_valid && (w_rd_tag == pc_i[XLEN-1:IDX_W+2]);
   assign w_upd_hit = w_rb_valid && (w_rb_tag == upd_pc_i[XLEN-1:IDX_W+2]);
   assign pred_o    = w_hit ? '{valid: 1'b1, taken: w_rd_state[1], target: w_rd_target,
                                state: w_rd_state} : '0;

   // Branch takes priority over jump if both flags are raised; JALR only ever invalidates.
   always_comb begin
      w_we        = 1'b0;
      w_wr_valid  = 1'b1;
      w_wr_target = upd_target_i;
      w_wr_state  = PRED_STRONG_TAKEN;
      if (upd_valid_i && upd_is_branch_i) begin
         w_we        = w_upd_hit || upd_taken_i;
         w_wr_state  = w_upd_hit ? sat_cnt_update(w_rb_state, upd_taken_i) : PRED_WEAK_TAKEN;
         w_wr_target = upd_taken_i ? upd_target_i : w_rb_target;
      end else if (upd_valid_i && upd_is_jump_i && upd_is_jalr_i) begin
         w_we        = w_upd_hit;
         w_wr_valid  = 1'b0;
         w_wr_target = w_rb_target;
         w_wr_state  = w_rb_state;
      end else if (upd_valid_i && upd_is_jump_i) begin
         w_we        = 1'b1;
      end
   end

`ifdef BPU_PERF_EN
   logic [CNT_W-1:0] r_lookups, r_hits, r_mispred;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lookups <= '0;
         r_hits    <= '0;
         r_mispred <= '0;
      end else begin
         r_lookups <= r_lookups + CNT_W'(~&r_lookups);
         r_hits    <= r_hits + CNT_W'(pred_o.valid & ~&r_hits);
         r_mispred <= r_mispred + CNT_W'(upd_valid_i & upd_mispred_i & ~&r_mispred);
      end
   end

   assign perf_lookups_o = r_lookups;
   assign perf_hits_o    = r_hits;
   assign perf_mispred_o = r_mispred;
   assign w_unused       = ^{pc_i[1:0], upd_pc_i[1:0]};
`else
   assign perf_lookups_o = '0;
   assign perf_hits_o    = '0;
   assign perf_mispred_o = '0;
   assign w_unused       = ^{pc_i[1:0], upd_pc_i[1:0], upd_mispred_i};
`endif

endmodule
